// File: rtl/collision_pkg.sv
// Shared types and point constants for the collision/scoring block.
// Score events are BCD amounts plus an add/subtract flag.
package collision_pkg;

   typedef struct packed {
      logic [23:0] amount;
      logic        add;
   } score_event_t;

   localparam logic [23:0] ENEMY_PTS_DEF = 24'h040000;
   localparam logic [23:0] HOOP_PTS_DEF  = 24'h160000;

endpackage

// File: rtl/score_event_fifo.sv
// Small score-event FIFO: simultaneous push/pop, push accepted when full only with a pop.
// Head reads as all-zero while empty.
module score_event_fifo
   import collision_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  score_event_t push_data,
   input  logic         pop,
   output score_event_t head,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         do_push, do_pop;
   score_event_t mem [DEPTH];

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      head     = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/collision_event_ctrl.sv
// Collision detection, per-frame hit pulses, hoop cooldown and score-event queueing.
// Optional GHOST_MODE_EN: ghost_mode masks player/tower collisions.
module collision_event_ctrl
   import collision_pkg::*;
#(
   parameter int          NUM_SHOTS     = 3,
   parameter int          FIFO_DEPTH    = 4,
   parameter logic [23:0] ENEMY_PTS     = ENEMY_PTS_DEF,
   parameter logic [23:0] HOOP_PTS      = HOOP_PTS_DEF,
   parameter int          HOOP_COOLDOWN = 30,
   parameter int          HOOP_TIME     = 60
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_of_frame,
   input  logic                 ghost_mode,
   input  logic                 dr_player,
   input  logic                 dr_enemy,
   input  logic                 dr_enemy_hu,
   input  logic                 dr_enemy_hd,
   input  logic                 dr_tower,
   input  logic                 dr_hoop,
   input  logic [NUM_SHOTS-1:0] dr_shot,
   output logic [NUM_SHOTS-1:0] shot_tower_hit,
   output logic                 tower_enemy_hu_hit,
   output logic                 shot_enemy_hd_hit,
   output logic                 hoop_tower_hit,
   output logic                 tower_player_hit,
   output logic [NUM_SHOTS-1:0] shot_enemy_hit,
   output logic                 life_remove,
   output logic                 time_req,
   output logic [10:0]          time_len,
   output logic                 event_lost,
   output logic                 score_valid,
   input  logic                 score_ready,
   output logic [23:0]          score_amount,
   output logic                 score_add
);

   localparam int CW = $clog2(HOOP_COOLDOWN + 1);

   logic [NUM_SHOTS-1:0] shot_flag_q, shot_flag_d;
   logic [NUM_SHOTS-1:0] shot_pulse_q, shot_pulse_d;
   logic [NUM_SHOTS-1:0] pend_q, pend_d;
   logic                 life_flag_q, life_flag_d;
   logic                 life_pulse_q, life_pulse_d;
   logic                 hoop_armed_q, hoop_armed_d;
   logic                 hoop_pend_q, hoop_pend_d;
   logic [CW-1:0]        cooldown_q, cooldown_d;
   logic                 time_req_q, time_req_d;
   logic [10:0]          time_len_q, time_len_d;
   logic                 event_lost_q, event_lost_d;

   logic [NUM_SHOTS-1:0] hit_now, shot_clr;
   logic                 hoop_hit, hoop_clr, enq_valid, can_push;
   logic                 fifo_full, fifo_empty, pop;
   score_event_t         enq_data, head;

   assign shot_tower_hit     = dr_shot & {NUM_SHOTS{dr_tower}};
   assign tower_enemy_hu_hit = dr_enemy_hu & dr_tower;
   assign shot_enemy_hd_hit  = (|dr_shot) & dr_enemy_hd;
   assign hoop_tower_hit     = dr_hoop & dr_tower;

`ifdef GHOST_MODE_EN
   assign tower_player_hit = dr_player & dr_tower & ~ghost_mode;
`else
   // ghost_mode has no effect in this build; the term folds to 1.
   assign tower_player_hit = dr_player & dr_tower & (ghost_mode | ~ghost_mode);
`endif

   assign pop      = ~fifo_empty & score_ready;
   assign can_push = ~fifo_full | pop;

   always_comb begin
      hit_now  = dr_shot & {NUM_SHOTS{dr_enemy}};
      hoop_hit = dr_player & dr_hoop & hoop_armed_q;

      // A new frame wipes the flags, so a collision on the frame pulse always counts.
      if (start_of_frame) begin
         shot_flag_d  = hit_now;
         shot_pulse_d = hit_now;
         life_flag_d  = tower_player_hit;
         life_pulse_d = tower_player_hit;
      end else begin
         shot_flag_d  = shot_flag_q | hit_now;
         shot_pulse_d = hit_now & ~shot_flag_q;
         life_flag_d  = life_flag_q | tower_player_hit;
         life_pulse_d = tower_player_hit & ~life_flag_q;
      end

      enq_valid = 1'b0;
      enq_data  = '0;
      shot_clr  = '0;
      hoop_clr  = 1'b0;
      if (can_push) begin
         if (hoop_pend_q) begin
            enq_valid       = 1'b1;
            hoop_clr        = 1'b1;
            enq_data.amount = HOOP_PTS;
            enq_data.add    = 1'b1;
         end else begin
            for (int i = 0; i < NUM_SHOTS; i++) begin
               if (pend_q[i] && !enq_valid) begin
                  enq_valid       = 1'b1;
                  shot_clr[i]     = 1'b1;
                  enq_data.amount = ENEMY_PTS;
                  enq_data.add    = 1'b1;
               end
            end
         end
      end

      pend_d       = (pend_q & ~shot_clr) | shot_pulse_d;
      event_lost_d = event_lost_q
                   | (|(pend_q & ~shot_clr & shot_pulse_d))
                   | (hoop_pend_q & ~hoop_clr & hoop_hit);

      hoop_armed_d = hoop_armed_q;
      cooldown_d   = cooldown_q;
      hoop_pend_d  = hoop_pend_q & ~hoop_clr;
      if (hoop_hit) begin
         hoop_armed_d = 1'b0;
         cooldown_d   = CW'(HOOP_COOLDOWN);
         hoop_pend_d  = 1'b1;
      end else if (!hoop_armed_q && start_of_frame) begin
         if (cooldown_q <= CW'(1)) begin
            cooldown_d   = '0;
            hoop_armed_d = 1'b1;
         end else begin
            cooldown_d = cooldown_q - 1'b1;
         end
      end

      time_req_d = hoop_hit;
      time_len_d = hoop_hit ? 11'(HOOP_TIME) : 11'd0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shot_flag_q  <= '0;
         shot_pulse_q <= '0;
         pend_q       <= '0;
         life_flag_q  <= 1'b0;
         life_pulse_q <= 1'b0;
         hoop_armed_q <= 1'b1;
         hoop_pend_q  <= 1'b0;
         cooldown_q   <= '0;
         time_req_q   <= 1'b0;
         time_len_q   <= '0;
         event_lost_q <= 1'b0;
      end else begin
         shot_flag_q  <= shot_flag_d;
         shot_pulse_q <= shot_pulse_d;
         pend_q       <= pend_d;
         life_flag_q  <= life_flag_d;
         life_pulse_q <= life_pulse_d;
         hoop_armed_q <= hoop_armed_d;
         hoop_pend_q  <= hoop_pend_d;
         cooldown_q   <= cooldown_d;
         time_req_q   <= time_req_d;
         time_len_q   <= time_len_d;
         event_lost_q <= event_lost_d;
      end
   end

   score_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (enq_valid),
      .push_data (enq_data),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign shot_enemy_hit = shot_pulse_q;
   assign life_remove    = life_pulse_q;
   assign time_req       = time_req_q;
   assign time_len       = time_len_q;
   assign event_lost     = event_lost_q;
   assign score_valid    = ~fifo_empty;
   assign score_amount   = head.amount;
   assign score_add      = head.add;

endmodule

// File: tb/tb_collision_event_ctrl.sv
// Directed bench for collision_event_ctrl; honours GHOST_MODE_EN if defined.
module tb_collision_event_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_of_frame = 1'b0, ghost_mode = 1'b0;
   logic        dr_player = 1'b0, dr_enemy = 1'b0, dr_enemy_hu = 1'b0, dr_enemy_hd = 1'b0;
   logic        dr_tower = 1'b0, dr_hoop = 1'b0;
   logic [2:0]  dr_shot = 3'b000;
   logic [2:0]  shot_tower_hit, shot_enemy_hit;
   logic        tower_enemy_hu_hit, shot_enemy_hd_hit, hoop_tower_hit, tower_player_hit;
   logic        life_remove, time_req, event_lost, score_valid, score_add;
   logic        score_ready = 1'b0;
   logic [10:0] time_len;
   logic [23:0] score_amount;

   int tests = 0;
   int failed = 0;
   int pops;
   int bad_amt;

   always #5 clk = ~clk;

   collision_event_ctrl dut (
      .clk(clk), .reset(reset), .start_of_frame(start_of_frame), .ghost_mode(ghost_mode),
      .dr_player(dr_player), .dr_enemy(dr_enemy), .dr_enemy_hu(dr_enemy_hu),
      .dr_enemy_hd(dr_enemy_hd), .dr_tower(dr_tower), .dr_hoop(dr_hoop), .dr_shot(dr_shot),
      .shot_tower_hit(shot_tower_hit), .tower_enemy_hu_hit(tower_enemy_hu_hit),
      .shot_enemy_hd_hit(shot_enemy_hd_hit), .hoop_tower_hit(hoop_tower_hit),
      .tower_player_hit(tower_player_hit), .shot_enemy_hit(shot_enemy_hit),
      .life_remove(life_remove), .time_req(time_req), .time_len(time_len),
      .event_lost(event_lost), .score_valid(score_valid), .score_ready(score_ready),
      .score_amount(score_amount), .score_add(score_add)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      dr_player = 0; dr_enemy = 0; dr_enemy_hu = 0; dr_enemy_hd = 0;
      dr_tower = 0; dr_hoop = 0; dr_shot = 3'b000;
   endtask

   task automatic frame();
      start_of_frame = 1; step(); start_of_frame = 0;
   endtask

   // One new frame, one enemy hit on channel ch, then one idle cycle.
   task automatic hit(input int ch);
      frame();
      dr_shot = 3'b000; dr_shot[ch] = 1'b1; dr_enemy = 1; step();
      clear_in(); step();
   endtask

   task automatic hoop_try();
      dr_player = 1; dr_hoop = 1; step(); clear_in();
   endtask

   initial begin
      step(); step();
      chk("rst_valid", 32'(score_valid), 32'd0);
      chk("rst_shot_hit", 32'(shot_enemy_hit), 32'd0);
      chk("rst_lost", 32'(event_lost), 32'd0);
      chk("rst_time_req", 32'(time_req), 32'd0);
      chk("rst_amount", 32'(score_amount), 32'd0);
      reset = 0;
      step();

      // Combinational collision outputs (cleared before the next edge)
      dr_shot = 3'b011; dr_tower = 1; dr_enemy_hu = 1; dr_enemy_hd = 1; dr_hoop = 1;
      #1;
      chk("shot_tower", 32'(shot_tower_hit), 32'h3);
      chk("tower_hu", 32'(tower_enemy_hu_hit), 32'd1);
      chk("shot_hd", 32'(shot_enemy_hd_hit), 32'd1);
      chk("hoop_tower", 32'(hoop_tower_hit), 32'd1);
      dr_shot = 3'b000; #1;
      chk("shot_hd_none", 32'(shot_enemy_hd_hit), 32'd0);
      clear_in(); step();

      // Life removal: once per frame
      frame();
      dr_player = 1; dr_tower = 1; #1;
      chk("tph", 32'(tower_player_hit), 32'd1);
      step();
      chk("life_first", 32'(life_remove), 32'd1);
      step();
      chk("life_second", 32'(life_remove), 32'd0);
      clear_in();
      frame();
      ghost_mode = 1; dr_player = 1; dr_tower = 1; #1;
`ifdef GHOST_MODE_EN
      chk("ghost_tph", 32'(tower_player_hit), 32'd0);
      step();
      chk("ghost_life", 32'(life_remove), 32'd0);
      ghost_mode = 0; step();
      chk("unghost_life", 32'(life_remove), 32'd1);
      step();
      chk("unghost_life_once", 32'(life_remove), 32'd0);
`else
      chk("ghost_ignored_tph", 32'(tower_player_hit), 32'd1);
      step();
      chk("ghost_ignored_life", 32'(life_remove), 32'd1);
`endif
      ghost_mode = 0; clear_in(); step();

      // Two channels hit at once, events queued in order
      frame();
      dr_shot = 3'b101; dr_enemy = 1; step();
      chk("seh_101", 32'(shot_enemy_hit), 32'h5);
      chk("valid_n1", 32'(score_valid), 32'd0);
      clear_in(); step();
      chk("seh_clear", 32'(shot_enemy_hit), 32'd0);
      chk("valid_n2", 32'(score_valid), 32'd1);
      chk("amt_ev1", 32'(score_amount), 32'h040000);
      chk("add_ev1", 32'(score_add), 32'd1);
      score_ready = 1; step();
      chk("valid_ev2", 32'(score_valid), 32'd1);
      chk("amt_ev2", 32'(score_amount), 32'h040000);
      step();
      chk("drained_valid", 32'(score_valid), 32'd0);
      chk("drained_amt", 32'(score_amount), 32'd0);

      // Repeated hits in one frame give one pulse; frame-pulse hit counts
      frame();
      dr_shot = 3'b010; dr_enemy = 1; step();
      chk("ch1_first", 32'(shot_enemy_hit), 32'h2);
      step();
      chk("ch1_second", 32'(shot_enemy_hit), 32'h0);
      step(); step(); step();
      chk("ch1_fifth", 32'(shot_enemy_hit), 32'h0);
      start_of_frame = 1; step(); start_of_frame = 0;
      chk("ch1_sof_hit", 32'(shot_enemy_hit), 32'h2);
      clear_in(); step(); step(); step();
      chk("ch1_no_lost", 32'(event_lost), 32'd0);
      chk("ch1_drained", 32'(score_valid), 32'd0);
      score_ready = 0;

      // Hoop pass and cooldown
      frame();
      hoop_try();
      chk("hoop_req", 32'(time_req), 32'd1);
      chk("hoop_len", 32'(time_len), 32'd60);
      step();
      chk("hoop_req_end", 32'(time_req), 32'd0);
      chk("hoop_len_end", 32'(time_len), 32'd0);
      chk("hoop_valid", 32'(score_valid), 32'd1);
      chk("hoop_amt", 32'(score_amount), 32'h160000);
      score_ready = 1; step(); score_ready = 0;
      hoop_try();
      chk("hoop_cool0", 32'(time_req), 32'd0);
      for (int k = 0; k < 29; k++) begin
         frame(); step();
      end
      hoop_try();
      chk("hoop_cool29", 32'(time_req), 32'd0);
      frame();
      hoop_try();
      chk("hoop_rearm", 32'(time_req), 32'd1);
      step();
      chk("hoop2_amt", 32'(score_amount), 32'h160000);
      score_ready = 1; step(); score_ready = 0;
      chk("hoop2_drained", 32'(score_valid), 32'd0);

      // Back-pressure: 6 hits into a depth-4 FIFO, none lost
      hit(0); hit(1); hit(2); hit(0); hit(1); hit(2);
      chk("bp_no_lost", 32'(event_lost), 32'd0);
      chk("bp_valid", 32'(score_valid), 32'd1);
      score_ready = 1;
      pops = 0; bad_amt = 0;
      for (int k = 0; k < 10; k++) begin
         if (score_valid) begin
            pops++;
            if (score_amount !== 24'h040000) bad_amt++;
         end
         step();
      end
      chk("bp_pops", 32'(pops), 32'd6);
      chk("bp_amounts", 32'(bad_amt), 32'd0);
      chk("bp_empty", 32'(score_valid), 32'd0);
      score_ready = 0;

      // Overflow of a pending bit sets sticky event_lost
      for (int k = 0; k < 5; k++) hit(0);
      chk("lost_not_yet", 32'(event_lost), 32'd0);
      hit(0);
      chk("lost_set", 32'(event_lost), 32'd1);
      step(); step();
      chk("lost_sticky", 32'(event_lost), 32'd1);
      score_ready = 1;
      for (int k = 0; k < 10; k++) step();
      score_ready = 0;
      chk("lost_drained", 32'(score_valid), 32'd0);

      // Reset mid-operation with 3 queued and hoop disarmed
      hit(0); hit(1); hit(2);
      chk("pre_rst_valid", 32'(score_valid), 32'd1);
      hoop_try();
      chk("pre_rst_disarmed", 32'(time_req), 32'd0);
      reset = 1; #1;
      chk("async_rst_valid", 32'(score_valid), 32'd0);
      chk("async_rst_lost", 32'(event_lost), 32'd0);
      step();
      reset = 0; score_ready = 1; step(); step();
      chk("post_rst_valid", 32'(score_valid), 32'd0);
      hoop_try();
      chk("post_rst_armed", 32'(time_req), 32'd1);
      score_ready = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
